// File: rtl/axi_burst_pkg.sv
// axi_burst_pkg: shared FSM type, AXI constants and helpers for the burst master
package axi_burst_pkg;
  typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA, DONE} state_t;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic [2:0] axsize_f(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction
  // Response codes are ordered by severity, so the numerically larger one wins.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/axi_burst_master_p_splitter.sv
// axi_4k_splitter: sizes the next INCR burst so it never crosses a 4 KB boundary
module axi_4k_splitter #(
  parameter int DATA_W = 64
) (
  input  logic [11:0] i_addr,
  input  logic [8:0]  i_remaining,
  output logic [8:0]  o_beats,
  output logic [7:0]  o_axlen
);
  localparam int SZ = $clog2(DATA_W / 8);
  logic [12:0] w_to_bound;
  logic [8:0]  w_len;
  assign w_to_bound = (13'd4096 - {1'b0, i_addr}) >> SZ;
  // When the boundary is closer than the remaining count it is below 256, so 9 bits suffice.
  assign o_beats = ({4'b0, i_remaining} < w_to_bound) ? i_remaining : w_to_bound[8:0];
  assign w_len   = o_beats - 9'd1;
  assign o_axlen = w_len[7:0];
endmodule

// File: rtl/axi_burst_master_p.sv
// axi_burst_master_p: executes one user read/write command as 4 KB-safe AXI4 INCR bursts
module axi_burst_master_p
  import axi_burst_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              user_start,
  input  logic              user_w_r,
  input  logic [ADDR_W-1:0] user_addr_in,
  input  logic [LEN_W-1:0]  user_burst_len_in,
  input  logic [STRB_W-1:0] user_data_strb,
  output logic              user_free,
  input  logic [DATA_W-1:0] user_data_in,
  input  logic              user_data_valid,
  output logic              user_data_ready,
  output logic [DATA_W-1:0] user_data_out,
  output logic              user_data_out_en,
  output logic [1:0]        user_status,
  output logic              user_done,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);
  localparam int SZ = $clog2(STRB_W);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0]        r_rem;
  logic [STRB_W-1:0] r_strb;
  logic [1:0]        r_status;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic [8:0]        w_beats;
  logic [7:0]        w_axlen;
  logic              w_whs, w_bhs, w_rhs, w_adv, w_last_sub;
  axi_4k_splitter #(.DATA_W(DATA_W)) u_split (
    .i_addr     (r_addr[11:0]),
    .i_remaining(r_rem),
    .o_beats    (w_beats),
    .o_axlen    (w_axlen)
  );
  assign w_whs      = (r_state == W_DATA) && user_data_valid && m_axi_wready;
  assign w_bhs      = (r_state == W_RESP) && m_axi_bvalid;
  assign w_rhs      = (r_state == R_DATA) && m_axi_rvalid;
  assign w_adv      = w_bhs || (w_rhs && m_axi_rlast);
  assign w_last_sub = (r_rem == w_beats);
  assign user_free        = (r_state == IDLE);
  assign user_done        = (r_state == DONE);
  assign user_status      = r_status;
  assign user_data_out    = r_rdata;
  assign user_data_out_en = r_rvalid;
  assign user_data_ready  = (r_state == W_DATA) && m_axi_wready;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = w_axlen;
  assign m_axi_awsize  = axsize_f(DATA_W);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awvalid = (r_state == W_ADDR);
  assign m_axi_wdata   = user_data_in;
  assign m_axi_wstrb   = r_strb;
  assign m_axi_wlast   = (r_cnt == w_axlen);
  assign m_axi_wvalid  = (r_state == W_DATA) && user_data_valid;
  assign m_axi_bready  = (r_state == W_RESP);
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = w_axlen;
  assign m_axi_arsize  = axsize_f(DATA_W);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = (r_state == R_ADDR);
  assign m_axi_rready  = (r_state == R_DATA);
  always_ff @(posedge aclk or posedge areset)
    if (areset) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = user_start ? (user_w_r ? R_ADDR : W_ADDR) : IDLE;
      W_ADDR:  w_next = m_axi_awready ? W_DATA : W_ADDR;
      W_DATA:  w_next = (w_whs && m_axi_wlast) ? W_RESP : W_DATA;
      W_RESP:  w_next = w_bhs ? (w_last_sub ? DONE : W_ADDR) : W_RESP;
      R_ADDR:  w_next = m_axi_arready ? R_DATA : R_ADDR;
      R_DATA:  w_next = (w_rhs && m_axi_rlast) ? (w_last_sub ? DONE : R_ADDR) : R_DATA;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_addr   <= '0;
      r_rem    <= '0;
      r_strb   <= '0;
      r_status <= RESP_OKAY;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rhs;
      if (w_rhs) r_rdata <= m_axi_rdata;
      if (r_state == IDLE && user_start) begin
        r_addr   <= user_addr_in & ~ADDR_W'(STRB_W - 1);
        r_rem    <= 9'(user_burst_len_in) + 9'd1;
        r_strb   <= user_data_strb;
        r_status <= RESP_OKAY;
      end
      if (w_bhs) r_status <= worst_resp(r_status, m_axi_bresp);
      if (w_rhs) r_status <= worst_resp(r_status, m_axi_rresp);
      // Address advance wraps naturally modulo 2^ADDR_W.
      if (w_adv) begin
        r_rem  <= r_rem - w_beats;
        r_addr <= r_addr + (ADDR_W'(w_beats) << SZ);
      end
      if (w_whs) r_cnt <= m_axi_wlast ? 8'd0 : r_cnt + 8'd1;
    end
  end
endmodule
